// File: rtl/rej_sample_stream_if.sv
// Handshake bundle for rej_sample_stream: XOF byte input stream and
// indexed coefficient output stream.
interface rej_sample_stream_if #(
    parameter int N = 256
);
    localparam int IW = $clog2(N + 1);

    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [11:0]   out_data;
    logic [IW-1:0] out_idx;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_idx, out_valid
    );
endinterface

// File: rtl/rej_sample_stream.sv
// Streaming Kyber uniform rejection sampler: 3 XOF bytes -> two 12-bit
// candidates, those below Q emitted as indexed coefficients until N or budget.
module rej_sample_stream #(
    parameter int Q         = 3329,
    parameter int N         = 256,
    parameter int MAX_BYTES = 504
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    rej_sample_stream_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [15:0]          bytes_used
);
    localparam int IW = $clog2(N + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] EMIT    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [IW-1:0] N_LAST = IW'(N - 1);
    localparam logic [15:0]   BUDGET = 16'(MAX_BYTES);
    localparam logic [12:0]   QV     = 13'(Q);

    logic [1:0]    state;
    logic [1:0]    bsel;
    logic [7:0]    b0, b1;
    logic [11:0]   c0, c1;
    logic          v0, v1, a0, a1;
    logic [IW-1:0] count;

    logic [11:0] d1, d2;
    logic        acc1, acc2, head_acc, last_entry;

    always_comb begin
        d1         = {b1[3:0], b0};
        d2         = {bus.in_data, b1[7:4]};
        acc1       = {1'b0, d1} < QV;
        acc2       = {1'b0, d2} < QV;
        head_acc   = v0 ? a0 : a1;
        last_entry = !(v0 && v1);
    end

    // Entry 0 is always the head while valid; entry 1 follows it.
    assign bus.in_ready  = (state == COLLECT);
    assign bus.out_valid = (state == EMIT) && (v0 || v1) && head_acc;
    assign bus.out_data  = v0 ? c0 : c1;
    assign bus.out_idx   = count;
    assign busy          = (state == COLLECT) || (state == EMIT);
    assign done          = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bsel       <= '0;
            b0         <= '0;
            b1         <= '0;
            c0         <= '0;
            c1         <= '0;
            v0         <= 1'b0;
            v1         <= 1'b0;
            a0         <= 1'b0;
            a1         <= 1'b0;
            count      <= '0;
            fail       <= 1'b0;
            bytes_used <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= COLLECT;
                        bsel       <= '0;
                        v0         <= 1'b0;
                        v1         <= 1'b0;
                        count      <= '0;
                        fail       <= 1'b0;
                        bytes_used <= '0;
                    end
                end
                COLLECT: begin
                    if (bus.in_valid) begin
                        bytes_used <= bytes_used + 16'd1;
                        case (bsel)
                            2'd0: begin
                                b0   <= bus.in_data;
                                bsel <= 2'd1;
                            end
                            2'd1: begin
                                b1   <= bus.in_data;
                                bsel <= 2'd2;
                            end
                            default: begin
                                c0    <= d1;
                                c1    <= d2;
                                a0    <= acc1;
                                a1    <= acc2;
                                v0    <= 1'b1;
                                v1    <= 1'b1;
                                bsel  <= '0;
                                state <= EMIT;
                            end
                        endcase
                    end
                end
                EMIT: begin
                    if (v0 || v1) begin
                        // Rejects leave unconditionally; accepts leave on the output handshake.
                        if (!head_acc || bus.out_ready) begin
                            if (v0) v0 <= 1'b0;
                            else    v1 <= 1'b0;
                            if (head_acc) count <= count + IW'(1);
                            if (head_acc && count == N_LAST) begin
                                state <= DONE;
                            end else if (last_entry) begin
                                if (BUDGET != 16'd0 && bytes_used == BUDGET) begin
                                    fail  <= 1'b1;
                                    state <= DONE;
                                end else begin
                                    state <= COLLECT;
                                end
                            end
                        end
                    end else begin
                        state <= COLLECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rej_sample_stream.sv
// Self-checking bench for rej_sample_stream: three parameterisations driven
// from random/directed byte streams and compared against a triplet-level model.
`timescale 1ns/1ps
module tb_rej_sample_stream;
    localparam int Q  = 3329;
    localparam int NA = 256, MA = 504;
    localparam int NB = 3,   MB = 504;
    localparam int NC = 256, MC = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  start_s = '0;
    logic [2:0]  valid_s = '0;
    logic [7:0]  data_s = '0;
    logic        oready_s = 1'b0;

    logic        busy_a, done_a, fail_a, busy_b, done_b, fail_b, busy_c, done_c, fail_c;
    logic [15:0] bu_a, bu_b, bu_c;

    rej_sample_stream_if #(.N(NA)) ia ();
    rej_sample_stream_if #(.N(NB)) ib ();
    rej_sample_stream_if #(.N(NC)) ic ();

    assign ia.in_data = data_s;  assign ia.in_valid = valid_s[0]; assign ia.out_ready = oready_s;
    assign ib.in_data = data_s;  assign ib.in_valid = valid_s[1]; assign ib.out_ready = oready_s;
    assign ic.in_data = data_s;  assign ic.in_valid = valid_s[2]; assign ic.out_ready = oready_s;

    rej_sample_stream #(.Q(Q), .N(NA), .MAX_BYTES(MA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .bus(ia),
        .busy(busy_a), .done(done_a), .fail(fail_a), .bytes_used(bu_a));
    rej_sample_stream #(.Q(Q), .N(NB), .MAX_BYTES(MB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .bus(ib),
        .busy(busy_b), .done(done_b), .fail(fail_b), .bytes_used(bu_b));
    rej_sample_stream #(.Q(Q), .N(NC), .MAX_BYTES(MC)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .bus(ic),
        .busy(busy_c), .done(done_c), .fail(fail_c), .bytes_used(bu_c));

    int sel = 0;
    logic        o_ir, o_ov, o_busy, o_done, o_fail;
    logic [11:0] o_od;
    logic [31:0] o_oi;
    logic [15:0] o_bu;

    always_comb begin
        case (sel)
            0: begin
                o_ir = ia.in_ready; o_ov = ia.out_valid; o_od = ia.out_data; o_oi = 32'(ia.out_idx);
                o_busy = busy_a; o_done = done_a; o_fail = fail_a; o_bu = bu_a;
            end
            1: begin
                o_ir = ib.in_ready; o_ov = ib.out_valid; o_od = ib.out_data; o_oi = 32'(ib.out_idx);
                o_busy = busy_b; o_done = done_b; o_fail = fail_b; o_bu = bu_b;
            end
            default: begin
                o_ir = ic.in_ready; o_ov = ic.out_valid; o_od = ic.out_data; o_oi = 32'(ic.out_idx);
                o_busy = busy_c; o_done = done_c; o_fail = fail_c; o_bu = bu_c;
            end
        endcase
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] stream[$];
    int exp_q[$];
    int exp_bu;
    int exp_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: walk the stream triplet by triplet applying the sampling rules.
    task automatic model(input int n, input int maxb);
        int used, d1, d2;
        exp_q.delete();
        used = 0;
        exp_fail = 0;
        for (int i = 0; i + 2 < stream.size(); i += 3) begin
            d1 = int'(stream[i]) + 256 * int'(stream[i+1] & 8'h0F);
            d2 = int'(stream[i+1] >> 4) + 16 * int'(stream[i+2]);
            used += 3;
            if (d1 < Q) exp_q.push_back(d1);
            if (exp_q.size() < n && d2 < Q) exp_q.push_back(d2);
            if (exp_q.size() == n) break;
            if (maxb != 0 && used == maxb) begin
                exp_fail = 1;
                break;
            end
        end
        exp_bu = used;
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_in_ready"},   32'(o_ir),   0);
        chk({pfx, "_out_valid"},  32'(o_ov),   0);
        chk({pfx, "_out_data"},   32'(o_od),   0);
        chk({pfx, "_out_idx"},    o_oi,        0);
        chk({pfx, "_busy"},       32'(o_busy), 0);
        chk({pfx, "_done"},       32'(o_done), 0);
        chk({pfx, "_fail"},       32'(o_fail), 0);
        chk({pfx, "_bytes_used"}, 32'(o_bu),   0);
    endtask

    task automatic run(input int s, input int n, input int maxb, input int pv, input int pr,
                       input bit stall5);
        int p, k, hold;
        bit stalled, last_hs, fin;
        logic [31:0] sd, si;
        model(n, maxb);
        sel = s;
        @(negedge clk);
        start_s[s] = 1'b1;
        @(negedge clk);
        start_s = '0;
        chk("busy_after_start", 32'(o_busy), 1);
        chk("in_ready_after_start", 32'(o_ir), 1);
        chk("fail_cleared_on_start", 32'(o_fail), 0);
        chk("bytes_cleared_on_start", 32'(o_bu), 0);
        p = 0; k = 0; stalled = 0; last_hs = 0; fin = 0; sd = '0; si = '0;
        hold = stall5 ? 5 : 0;
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            if (last_hs && k == exp_q.size() && exp_fail == 0)
                chk("done_after_last_handshake", 32'(o_done), 1);
            last_hs = 0;
            if (o_done) begin
                fin = 1;
            end else begin
                if (stalled) begin
                    chk("stall_out_valid", 32'(o_ov), 1);
                    chk("stall_out_data", 32'(o_od), sd);
                    chk("stall_out_idx", o_oi, si);
                end
                valid_s[s] = (p < stream.size()) && ($urandom_range(99) < pv);
                data_s = valid_s[s] ? stream[p] : 8'($urandom);
                if (valid_s[s] && o_ir) p++;
                oready_s = ($urandom_range(99) < pr);
                if (o_ov && hold > 0) begin
                    oready_s = 1'b0;
                    hold--;
                end
                stalled = o_ov && !oready_s;
                if (o_ov) begin
                    sd = 32'(o_od);
                    si = o_oi;
                end
                if (o_ov && oready_s) begin
                    chk("out_idx", o_oi, k);
                    if (k < exp_q.size()) chk("out_data", 32'(o_od), exp_q[k]);
                    else chk("out_valid_extra", 32'(o_ov), 0);
                    k++;
                    last_hs = 1;
                end
                @(negedge clk);
            end
        end
        valid_s = '0;
        oready_s = 1'b0;
        chk("done_seen", 32'(fin), 1);
        chk("bytes_used_final", 32'(o_bu), exp_bu);
        chk("fail_final", 32'(o_fail), exp_fail);
        chk("coef_count", k, exp_q.size());
        chk("bytes_handshaked", p, exp_bu);
        @(negedge clk);
        chk("done_single_cycle", 32'(o_done), 0);
        chk("busy_after_done", 32'(o_busy), 0);
        chk("bytes_used_held", 32'(o_bu), exp_bu);
        chk("fail_held", 32'(o_fail), exp_fail);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        reset_checks("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // N=3: 513, 48, 3328 then the trailing 0 is discarded
        stream = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h0D, 8'h00};
        for (int i = 0; i < 6; i++) stream.push_back(8'($urandom));
        run(1, NB, MB, 100, 100, 1'b0);

        // Defaults: boundary triplets, then 0xFF reject triplets interleaved with 01 02 03
        stream = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h0D, 8'h00, 8'h01, 8'h0D, 8'hD0};
        for (int i = 0; i < 200; i++) begin
            if (i % 5 == 0) begin
                stream.push_back(8'hFF); stream.push_back(8'hFF); stream.push_back(8'hFF);
            end else begin
                stream.push_back(8'h01); stream.push_back(8'h02); stream.push_back(8'h03);
            end
        end
        run(0, NA, MA, 70, 60, 1'b1);

        stream.delete();
        for (int i = 0; i < 600; i++) stream.push_back(8'($urandom));
        run(0, NA, MA, 50, 50, 1'b0);

        // Budget of 6 bytes: all rejects -> fail; rerun clears fail on start
        stream.delete();
        for (int i = 0; i < 30; i++) stream.push_back(8'hFF);
        run(2, NC, MC, 80, 100, 1'b0);
        stream.delete();
        for (int i = 0; i < 10; i++) begin
            stream.push_back(8'h01); stream.push_back(8'h02); stream.push_back(8'h03);
        end
        run(2, NC, MC, 60, 40, 1'b0);

        // Reset while a coefficient is being presented
        sel = 0;
        stream = '{8'h01, 8'h02, 8'h03};
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s = '0;
        oready_s = 1'b0;
        begin
            int p;
            p = 0;
            for (int cyc = 0; cyc < 40 && !o_ov; cyc++) begin
                valid_s[0] = (p < 3);
                data_s = (p < 3) ? stream[p] : 8'h00;
                if (valid_s[0] && o_ir) p++;
                @(negedge clk);
            end
        end
        valid_s = '0;
        chk("emit_before_reset", 32'(o_ov), 1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        stream.delete();
        for (int i = 0; i < 600; i++) stream.push_back(8'($urandom));
        run(0, NA, MA, 100, 100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
